// File: rtl/q1_batch_stats.sv
// rtl/q1_batch_stats.sv - batch sum/max/min collector for the Q1 sample stream
// Gathers NUM_SAMPLES accepted samples and holds the result until the sink takes it.
module q1_batch_stats #(
   parameter int DATA_W      = 8,
   parameter int NUM_SAMPLES = 4,
   parameter int ACC_W       = 10
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic [DATA_W-1:0] q1_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  sum_out,
   output logic [DATA_W-1:0] max_out,
   output logic [DATA_W-1:0] min_out,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int CNT_W = (NUM_SAMPLES > 2) ? $clog2(NUM_SAMPLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

   typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [ACC_W-1:0]    r_acc_sum;
   logic [DATA_W-1:0]   r_acc_max;
   logic [DATA_W-1:0]   r_acc_min;
   logic [ACC_W-1:0]    r_sum_out;
   logic [DATA_W-1:0]   r_max_out;
   logic [DATA_W-1:0]   r_min_out;
   logic                r_out_valid;

   state_t              w_state_nx;
   logic [CNT_W-1:0]    w_cnt_nx;
   logic [ACC_W-1:0]    w_acc_sum_nx;
   logic [DATA_W-1:0]   w_acc_max_nx;
   logic [DATA_W-1:0]   w_acc_min_nx;
   logic [ACC_W-1:0]    w_sum_out_nx;
   logic [DATA_W-1:0]   w_max_out_nx;
   logic [DATA_W-1:0]   w_min_out_nx;
   logic                w_out_valid_nx;

   logic                w_accept;
   logic                w_first;
   logic [ACC_W-1:0]    w_new_sum;
   logic [DATA_W-1:0]   w_new_max;
   logic [DATA_W-1:0]   w_new_min;

   assign in_ready  = rstN && (r_state == ST_ACCUM);
   assign w_accept  = in_valid && in_ready;
   assign w_first   = (r_cnt == '0);

   // The first sample of a batch seeds the accumulators instead of merging.
   assign w_new_sum = (w_first ? '0 : r_acc_sum) + ACC_W'(q1_in);
   assign w_new_max = (w_first || (q1_in > r_acc_max)) ? q1_in : r_acc_max;
   assign w_new_min = (w_first || (q1_in < r_acc_min)) ? q1_in : r_acc_min;

   assign sum_out   = r_sum_out;
   assign max_out   = r_max_out;
   assign min_out   = r_min_out;
   assign out_valid = r_out_valid;

   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_state     <= ST_ACCUM;
         r_cnt       <= '0;
         r_acc_sum   <= '0;
         r_acc_max   <= '0;
         r_acc_min   <= '0;
         r_sum_out   <= '0;
         r_max_out   <= '0;
         r_min_out   <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_acc_sum   <= w_acc_sum_nx;
         r_acc_max   <= w_acc_max_nx;
         r_acc_min   <= w_acc_min_nx;
         r_sum_out   <= w_sum_out_nx;
         r_max_out   <= w_max_out_nx;
         r_min_out   <= w_min_out_nx;
         r_out_valid <= w_out_valid_nx;
      end
   end

   always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = r_cnt;
      w_acc_sum_nx   = r_acc_sum;
      w_acc_max_nx   = r_acc_max;
      w_acc_min_nx   = r_acc_min;
      w_sum_out_nx   = r_sum_out;
      w_max_out_nx   = r_max_out;
      w_min_out_nx   = r_min_out;
      w_out_valid_nx = r_out_valid;
      case (r_state)
         ST_ACCUM: begin
            if (w_accept) begin
               if (r_cnt == LAST_CNT) begin
                  w_sum_out_nx   = w_new_sum;
                  w_max_out_nx   = w_new_max;
                  w_min_out_nx   = w_new_min;
                  w_out_valid_nx = 1'b1;
                  w_acc_sum_nx   = '0;
                  w_acc_max_nx   = '0;
                  w_acc_min_nx   = '0;
                  w_cnt_nx       = '0;
                  w_state_nx     = ST_HOLD;
               end else begin
                  w_acc_sum_nx   = w_new_sum;
                  w_acc_max_nx   = w_new_max;
                  w_acc_min_nx   = w_new_min;
                  w_cnt_nx       = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_HOLD: begin
            // Output data regs are left as-is after handoff; only valid drops.
            if (r_out_valid && out_ready) begin
               w_out_valid_nx = 1'b0;
               w_acc_sum_nx   = '0;
               w_acc_max_nx   = '0;
               w_acc_min_nx   = '0;
               w_state_nx     = ST_ACCUM;
            end
         end
         default: w_state_nx = ST_ACCUM;
      endcase
   end

endmodule

// File: tb/tb_q1_batch_stats.sv
// tb/tb_q1_batch_stats.sv - directed self-checking bench for q1_batch_stats
module tb_q1_batch_stats;

   logic        clk;
   logic        rstN;
   logic [7:0]  q1_in;
   logic        in_valid;
   logic        in_ready;
   logic [9:0]  sum_out;
   logic [7:0]  max_out;
   logic [7:0]  min_out;
   logic        out_valid;
   logic        out_ready;

   int total = 0;
   int bad   = 0;

   q1_batch_stats #(.DATA_W(8), .NUM_SAMPLES(4), .ACC_W(10)) dut (
      .clk       (clk),
      .rstN      (rstN),
      .q1_in     (q1_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_out   (sum_out),
      .max_out   (max_out),
      .min_out   (min_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [7:0] x);
      in_valid = 1'b1;
      q1_in    = x;
      step();
      in_valid = 1'b0;
   endtask

   task automatic chk_result(input string tag, input int s, input int mx, input int mn);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"},   32'(sum_out),   32'(s));
      chk({tag, "_max"},   32'(max_out),   32'(mx));
      chk({tag, "_min"},   32'(min_out),   32'(mn));
   endtask

   logic [7:0] gap_data  [7] = '{8'd5, 8'd0, 8'd0, 8'd3, 8'd0, 8'd9, 8'd1};
   logic       gap_valid [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      rstN      = 1'b0;
      in_valid  = 1'b1;
      q1_in     = 8'd99;
      out_ready = 1'b1;

      // Reset held two cycles with in_valid asserted
      step();
      step();
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",       32'(sum_out),   32'd0);
      chk("rst_max",       32'(max_out),   32'd0);
      chk("rst_min",       32'(min_out),   32'd0);
      in_valid = 1'b0;
      rstN     = 1'b1;
      step();
      chk("rel_in_ready",  32'(in_ready),  32'd1);

      // Back-to-back batch, sink ready
      feed(8'd10);
      feed(8'd20);
      feed(8'd30);
      chk("b2b_not_early", 32'(out_valid), 32'd0);
      feed(8'd40);
      chk_result("b2b", 100, 40, 10);
      chk("b2b_hold_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("b2b_one_cycle",  32'(out_valid), 32'd0);
      chk("b2b_ready_back", 32'(in_ready),  32'd1);

      // All-max samples: no wrap
      for (int i = 0; i < 4; i++) feed(8'd255);
      chk_result("sat", 1020, 255, 255);
      step();

      // Back-pressure: result held while sink stalls, offered 7 must not be absorbed
      out_ready = 1'b0;
      feed(8'd1);
      feed(8'd2);
      feed(8'd3);
      feed(8'd4);
      chk_result("bp_first", 10, 4, 1);
      in_valid = 1'b1;
      q1_in    = 8'd7;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_sum",       32'(sum_out),   32'd10);
         chk("bp_max",       32'(max_out),   32'd4);
      end
      out_ready = 1'b1;
      step();
      chk("bp_handoff_valid", 32'(out_valid), 32'd0);
      chk("bp_handoff_ready", 32'(in_ready),  32'd1);
      step();
      feed(8'd8);
      feed(8'd9);
      feed(8'd10);
      chk_result("bp_next", 34, 10, 7);
      step();

      // Gapped input
      for (int i = 0; i < 7; i++) begin
         in_valid = gap_valid[i];
         q1_in    = gap_data[i];
         step();
      end
      in_valid = 1'b0;
      chk_result("gap", 18, 9, 1);
      step();

      // Reset mid-batch discards the partial batch
      feed(8'd50);
      feed(8'd60);
      rstN = 1'b0;
      step();
      chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      rstN = 1'b1;
      feed(8'd1);
      feed(8'd2);
      feed(8'd3);
      chk("mid_rst_not_early", 32'(out_valid), 32'd0);
      feed(8'd4);
      chk_result("mid_rst", 10, 4, 1);
      step();
      chk("final_idle", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
